instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter IW, default 8, instruction width in bits.
REQ-002 SHALL have parameter AW, default 8, address (PC) width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, number of instruction words (1 <= DEPTH <= 2**AW).
REQ-004 SHALL have parameter NOP_INSTR, default 8'b0000_0000 (IW bits), word returned for unloaded or out-of-range locations.
REQ-005 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have: prog_en  in  1  program-load request; rising edge starts a load.
REQ-008 SHALL have: prog_valid  in  1  prog_data valid this cycle.
REQ-009 SHALL have: prog_data  in  IW  instruction word to store.
REQ-010 SHALL have: prog_ready  out  1  block accepts a load word this cycle.
REQ-011 SHALL have: prog_done  out  1  one-cycle pulse at end of load.
REQ-012 SHALL have: load_count  out  AW+1  number of words written in the last/current load.
REQ-013 SHALL have: pc  in  AW  fetch address.
REQ-014 SHALL have: fetch_req  in  1  fetch request.
REQ-015 SHALL have: stall  in  1  hold fetch outputs.
REQ-016 SHALL have: flush  in  1  discard fetched instruction.
REQ-017 SHALL have: instr  out  IW  fetched instruction (registered).
REQ-018 SHALL have: instr_valid  out  1  instr/instr_pc valid.
REQ-019 SHALL have: instr_pc  out  AW  address of instr.
REQ-020 SHALL have: fault  out  1  one-cycle pulse on fetch with pc >= DEPTH.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, RUN; reset state IDLE.
REQ-022 SHALL detect rising edge of prog_en via a registered copy (reset to 0); edge in any state -> LOAD, write pointer = 0, load_count = 0, all per-word loaded flags cleared, instr_valid = 0 next cycle.
REQ-023 IDLE: fetch_req with no prog_en edge -> RUN (unloaded memory reads NOP_INSTR).
REQ-024 LOAD: prog_ready = 1; each cycle with prog_valid & prog_ready writes mem[wptr] = prog_data, sets loaded flag[wptr], increments wptr and load_count.
REQ-025 LOAD exits to RUN with prog_done = 1 for one cycle when prog_en is low, or on the cycle the word at address DEPTH-1 is written (full); prog_ready = 0 from the following cycle.
REQ-026 After a full exit with prog_en still high, SHALL ignore prog_valid and stay in RUN until a new prog_en rising edge.
REQ-027 prog_en falling in the same cycle as a valid write: word SHALL be written, then exit.
REQ-028 Fetch latency SHALL be 1 cycle: RUN & fetch_req & !stall & !flush at edge N -> at N+1 instr = mem[pc] (or NOP_INSTR if flag clear or pc >= DEPTH), instr_pc = pc, instr_valid = 1.
REQ-029 RUN & !fetch_req & !stall & !flush -> instr_valid = 0 next cycle, instr and instr_pc hold.
REQ-030 stall = 1 (no flush) SHALL hold instr, instr_pc, instr_valid unchanged.
REQ-031 flush = 1 SHALL take priority over stall and fetch_req: next cycle instr_valid = 0, instr = NOP_INSTR.
REQ-032 fault SHALL pulse for one cycle coincident with the instr_valid of an out-of-range fetch; instr = NOP_INSTR.
REQ-033 fetch_req in IDLE-to-RUN transition or in LOAD SHALL produce no instruction (instr_valid = 0).
REQ-034 Memory array SHALL not be reset; only loaded flags are cleared.

Reset
REQ-035 reset low SHALL immediately force: state IDLE, instr = NOP_INSTR, instr_valid 0, instr_pc 0, prog_ready 0, prog_done 0, fault 0, load_count 0, wptr 0, prog_en register 0, all loaded flags 0.
REQ-036 reset asserted mid-load SHALL abandon the load; after release, all locations read NOP_INSTR until reloaded.

Verification
REQ-037 Load 6 words 0x1D,0x59,0x2B,0xC5,0x6B,0x02 then drop prog_en -> prog_done pulse, load_count = 6; fetch pc 0..5 -> same words one cycle later, instr_pc matches.
REQ-038 Fetch pc = 10 after 6-word load -> instr = 0x00, instr_valid = 1, fault = 0.
REQ-039 DEPTH = 4: stream 6 words with prog_en held high -> only first 4 stored, prog_done after 4th, load_count = 4, prog_ready = 0 afterwards; fetch pc = 5 (AW=3) -> instr 0x00, fault = 1.
REQ-040 Fetch pc 2 then stall 3 cycles with pc changing -> instr = 0x2B, instr_pc = 2 held; stall+flush same cycle -> instr_valid = 0 next cycle.
REQ-041 Reset low after 3 of 6 load words -> all outputs at REQ-035 values; after release fetch pc 0 -> 0x00.
REQ-042 In RUN, new prog_en edge -> instr_valid drops, prog_ready = 1, reload 2 words -> pc 2 reads 0x00.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming program-load port and a 1-cycle fetch port.
// Load: a rising edge on prog_en clears all loaded flags and streams words in from
// address 0. Fetch: registered read with stall/flush handling. Unloaded or
// out-of-range locations return NOP_INSTR.
module instr_mem_loader #(
  parameter int              IW        = 8,
  parameter int              AW        = 8,
  parameter int              DEPTH     = 256,
  parameter logic [IW-1:0]   NOP_INSTR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_en,
  input  logic          prog_valid,
  input  logic [IW-1:0] prog_data,
  output logic          prog_ready,
  output logic          prog_done,
  output logic [AW:0]   load_count,
  input  logic [AW-1:0] pc,
  input  logic          fetch_req,
  input  logic          stall,
  input  logic          flush,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] instr_pc,
  output logic          fault
);

  localparam int              IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state_q, state_d;
  logic              prog_en_q;
  logic              rise;
  logic              wr_en;
  logic              load_exit;
  logic [IDXW-1:0]   wptr_q;
  logic [DEPTH-1:0]  loaded_q;
  logic [IW-1:0]     mem [DEPTH];
  logic              pc_in_range;
  logic [IDXW-1:0]   pc_idx;
  logic [IW-1:0]     rd_word;

  assign rise = prog_en & ~prog_en_q;

  // Read-side decode: range check and flag-gated memory lookup
  always_comb begin
    pc_in_range = ({1'b0, pc} < DEPTH_W);
    pc_idx      = pc[IDXW-1:0];
    rd_word     = NOP_INSTR;
    if (pc_in_range && loaded_q[pc_idx])
      rd_word = mem[pc_idx];
  end

  // Next-state and load-port control; a new prog_en edge wins in every state
  always_comb begin
    state_d    = state_q;
    prog_ready = (state_q == LOAD);
    wr_en      = 1'b0;
    load_exit  = 1'b0;
    if (rise) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE: if (fetch_req) state_d = RUN;
        LOAD: begin
          // A word arriving with prog_en already low is still written
          wr_en = prog_valid;
          if (!prog_en || (prog_valid && wptr_q == LAST_IDX)) begin
            load_exit = 1'b1;
            state_d   = RUN;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and prog_en edge-detect copy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prog_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_en_q <= prog_en;
    end
  end

  // Load bookkeeping: write pointer, word count, loaded flags, done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      load_count <= '0;
      loaded_q   <= '0;
      prog_done  <= 1'b0;
    end else begin
      prog_done <= load_exit;
      if (rise) begin
        wptr_q     <= '0;
        load_count <= '0;
        loaded_q   <= '0;
      end else if (wr_en) begin
        loaded_q[wptr_q] <= 1'b1;
        wptr_q           <= wptr_q + IDXW'(1);
        load_count       <= load_count + (AW+1)'(1);
      end
    end
  end

  // Storage array; not reset, validity is tracked by loaded_q instead
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr_q] <= prog_data;
  end

  // Fetch output register: flush > stall > fetch_req; fault is a single-cycle pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      fault       <= 1'b0;
    end else begin
      fault <= 1'b0;
      if (rise || state_q != RUN) begin
        instr_valid <= 1'b0;
      end else if (flush) begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end else if (stall) begin
        instr_valid <= instr_valid;
      end else if (fetch_req) begin
        instr       <= rd_word;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        fault       <= ~pc_in_range;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a default-size instance (A) and a DEPTH=4, AW=3
// instance (B). Fetch expectations go through a scoreboard queue.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: IW=8, AW=8, DEPTH=256
  logic       a_en, a_valid, a_ready, a_done, a_freq, a_stall, a_flush, a_iv, a_fault;
  logic [7:0] a_data, a_pc, a_instr, a_ipc;
  logic [8:0] a_cnt;

  // Instance B: IW=8, AW=3, DEPTH=4
  logic       b_en, b_valid, b_ready, b_done, b_freq, b_stall, b_flush, b_iv, b_fault;
  logic [7:0] b_data, b_instr;
  logic [2:0] b_pc, b_ipc;
  logic [3:0] b_cnt;

  instr_mem_loader dut_a (
    .clk(clk), .reset(reset),
    .prog_en(a_en), .prog_valid(a_valid), .prog_data(a_data),
    .prog_ready(a_ready), .prog_done(a_done), .load_count(a_cnt),
    .pc(a_pc), .fetch_req(a_freq), .stall(a_stall), .flush(a_flush),
    .instr(a_instr), .instr_valid(a_iv), .instr_pc(a_ipc), .fault(a_fault)
  );

  instr_mem_loader #(.IW(8), .AW(3), .DEPTH(4), .NOP_INSTR(8'h00)) dut_b (
    .clk(clk), .reset(reset),
    .prog_en(b_en), .prog_valid(b_valid), .prog_data(b_data),
    .prog_ready(b_ready), .prog_done(b_done), .load_count(b_cnt),
    .pc(b_pc), .fetch_req(b_freq), .stall(b_stall), .flush(b_flush),
    .instr(b_instr), .instr_valid(b_iv), .instr_pc(b_ipc), .fault(b_fault)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
    logic       fault;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] words  [6] = '{8'h1D, 8'h59, 8'h2B, 8'hC5, 8'h6B, 8'h02};
  logic [7:0] bwords [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] ins, input logic [7:0] p, input logic f);
    exp_t e;
    e.instr = ins; e.pc = p; e.fault = f;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {a_en, a_valid, a_freq, a_stall, a_flush} = '0; a_data = '0; a_pc = '0;
    {b_en, b_valid, b_freq, b_stall, b_flush} = '0; b_data = '0; b_pc = '0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({a_instr, a_iv, a_ipc, a_ready, a_done, a_fault, a_cnt} !== {8'h00, 1'b0, 8'h00, 3'b000, 9'd0}) begin
      errors++;
      $display("FAIL reset_a: got instr=%h iv=%b ipc=%h rdy=%b done=%b flt=%b cnt=%0d", a_instr, a_iv, a_ipc, a_ready, a_done, a_fault, a_cnt);
    end
    checks++;
    if ({b_instr, b_iv, b_ipc, b_ready, b_done, b_fault, b_cnt} !== {8'h00, 1'b0, 3'h0, 3'b000, 4'd0}) begin
      errors++;
      $display("FAIL reset_b: got instr=%h iv=%b ipc=%h rdy=%b done=%b flt=%b cnt=%0d", b_instr, b_iv, b_ipc, b_ready, b_done, b_fault, b_cnt);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    a_en = 1'b1;
    tick();
    checks++;
    if ({a_ready, a_cnt} !== {1'b1, 9'd0}) begin
      errors++;
      $display("FAIL load_enter: got ready=%b cnt=%0d want ready=1 cnt=0", a_ready, a_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_data = words[i];
      tick();
    end
    a_valid = 1'b0; a_en = 1'b0;
    tick();
    checks++;
    if ({a_done, a_cnt, a_ready} !== {1'b1, 9'd6, 1'b0}) begin
      errors++;
      $display("FAIL load_done: got done=%b cnt=%0d ready=%b want 1/6/0", a_done, a_cnt, a_ready);
    end
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b want 0", a_done);
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      a_freq = 1'b1;
      a_pc   = (i < 6) ? 8'(i) : 8'd10;
      push_exp((i < 6) ? words[i] : 8'h00, a_pc, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if ({a_iv, a_instr, a_ipc, a_fault} !== {1'b1, e.instr, e.pc, e.fault}) begin
        errors++;
        $display("FAIL fetch_a pc=%0d: got iv=%b instr=%h ipc=%0d flt=%b want 1/%h/%0d/%b", e.pc, a_iv, a_instr, a_ipc, a_fault, e.instr, e.pc, e.fault);
      end
    end
    a_freq = 1'b0;
    tick();
    checks++;
    if ({a_iv, a_instr, a_ipc} !== {1'b0, 8'h00, 8'd10}) begin
      errors++;
      $display("FAIL idle_hold: got iv=%b instr=%h ipc=%0d want 0/00/10", a_iv, a_instr, a_ipc);
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    a_freq = 1'b1; a_pc = 8'd2;
    push_exp(8'h2B, 8'd2, 1'b0);
    tick();
    e = sbq.pop_front();
    checks++;
    if ({a_iv, a_instr, a_ipc} !== {1'b1, e.instr, e.pc}) begin
      errors++;
      $display("FAIL stall_pre: got iv=%b instr=%h ipc=%0d want 1/%h/%0d", a_iv, a_instr, a_ipc, e.instr, e.pc);
    end
    a_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_pc = 8'(3 + k);
      tick();
      checks++;
      if ({a_iv, a_instr, a_ipc} !== {1'b1, 8'h2B, 8'd2}) begin
        errors++;
        $display("FAIL stall_hold%0d: got iv=%b instr=%h ipc=%0d want 1/2b/2", k, a_iv, a_instr, a_ipc);
      end
    end
    a_flush = 1'b1;
    tick();
    checks++;
    if ({a_iv, a_instr} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL stall_flush: got iv=%b instr=%h want 0/00", a_iv, a_instr);
    end
    a_stall = 1'b0; a_flush = 1'b0; a_freq = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    a_freq = 1'b1; a_pc = 8'd1;
    push_exp(8'h59, 8'd1, 1'b0);
    tick();
    e = sbq.pop_front();
    checks++;
    if ({a_iv, a_instr, a_ipc} !== {1'b1, e.instr, e.pc}) begin
      errors++;
      $display("FAIL reload_pre: got iv=%b instr=%h ipc=%0d want 1/%h/%0d", a_iv, a_instr, a_ipc, e.instr, e.pc);
    end
    a_en = 1'b1;
    tick();
    checks++;
    if ({a_iv, a_ready, a_cnt, a_done} !== {1'b0, 1'b1, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL reload_enter: got iv=%b ready=%b cnt=%0d done=%b want 0/1/0/0", a_iv, a_ready, a_cnt, a_done);
    end
    a_valid = 1'b1; a_data = 8'h77;
    tick();
    checks++;
    if ({a_iv, a_cnt} !== {1'b0, 9'd1}) begin
      errors++;
      $display("FAIL reload_nofetch: got iv=%b cnt=%0d want 0/1", a_iv, a_cnt);
    end
    a_data = 8'h88; a_en = 1'b0;
    tick();
    checks++;
    if ({a_done, a_cnt, a_ready, a_iv} !== {1'b1, 9'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reload_exit: got done=%b cnt=%0d ready=%b iv=%b want 1/2/0/0", a_done, a_cnt, a_ready, a_iv);
    end
    a_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      a_pc = 8'(i);
      push_exp((i == 2) ? 8'h00 : (i == 1) ? 8'h88 : 8'h77, 8'(i), 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if ({a_iv, a_instr, a_ipc, a_fault} !== {1'b1, e.instr, e.pc, e.fault}) begin
        errors++;
        $display("FAIL reload_fetch pc=%0d: got iv=%b instr=%h ipc=%0d flt=%b want 1/%h/%0d/%b", e.pc, a_iv, a_instr, a_ipc, a_fault, e.instr, e.pc, e.fault);
      end
    end
    a_freq = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    exp_t e;
    a_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = words[i];
      tick();
    end
    a_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({a_instr, a_iv, a_ipc, a_ready, a_done, a_fault, a_cnt} !== {8'h00, 1'b0, 8'h00, 3'b000, 9'd0}) begin
      errors++;
      $display("FAIL midload_reset: got instr=%h iv=%b ipc=%h rdy=%b done=%b flt=%b cnt=%0d", a_instr, a_iv, a_ipc, a_ready, a_done, a_fault, a_cnt);
    end
    a_en = 1'b0;
    tick();
    reset = 1'b1;
    a_freq = 1'b1; a_pc = 8'd0;
    tick();
    checks++;
    if (a_iv !== 1'b0) begin
      errors++;
      $display("FAIL idle_to_run: got iv=%b want 0", a_iv);
    end
    push_exp(8'h00, 8'd0, 1'b0);
    tick();
    e = sbq.pop_front();
    checks++;
    if ({a_iv, a_instr, a_ipc, a_fault} !== {1'b1, e.instr, e.pc, e.fault}) begin
      errors++;
      $display("FAIL post_reset_fetch: got iv=%b instr=%h ipc=%0d flt=%b want 1/%h/%0d/%b", a_iv, a_instr, a_ipc, a_fault, e.instr, e.pc, e.fault);
    end
    a_freq = 1'b0;
    tick();
  endtask

  task automatic test_full();
    exp_t e;
    b_en = 1'b1;
    tick();
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_enter: got ready=%b want 1", b_ready);
    end
    for (int i = 0; i < 6; i++) begin
      b_valid = 1'b1; b_data = bwords[i];
      tick();
      if (i >= 3) begin
        checks++;
        if ({b_done, b_cnt, b_ready} !== {(i == 3), 4'd4, 1'b0}) begin
          errors++;
          $display("FAIL full_word%0d: got done=%b cnt=%0d ready=%b want %b/4/0", i, b_done, b_cnt, b_ready, (i == 3));
        end
      end
    end
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_freq = 1'b1;
      b_pc   = (i < 4) ? 3'(i) : 3'd5;
      push_exp((i < 4) ? bwords[i] : 8'h00, {5'd0, b_pc}, (i == 4));
      tick();
      e = sbq.pop_front();
      checks++;
      if ({b_iv, b_instr, b_ipc, b_fault} !== {1'b1, e.instr, e.pc[2:0], e.fault}) begin
        errors++;
        $display("FAIL fetch_b pc=%0d: got iv=%b instr=%h ipc=%0d flt=%b want 1/%h/%0d/%b", e.pc, b_iv, b_instr, b_ipc, b_fault, e.instr, e.pc, e.fault);
      end
    end
    b_freq = 1'b0;
    tick();
    checks++;
    if ({b_iv, b_fault} !== 2'b00) begin
      errors++;
      $display("FAIL fault_pulse: got iv=%b flt=%b want 0/0", b_iv, b_fault);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_stall_flush();
    test_back_to_back();
    test_reset_midload();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
